// File: rtl/bus_mem_responder.sv
// Simulation memory responder for the req/gnt/rvalid host bus.
// Configurable grant delay, response latency and outstanding limit.
module bus_mem_responder #(
   parameter int unsigned Depth          = 1024,
   parameter logic [31:0] AddrBase       = 32'h0,
   parameter int unsigned GntDelay       = 0,
   parameter int unsigned RspLatency     = 1,
   parameter int unsigned MaxOutstanding = 2
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        req_i,
   output logic        gnt_o,
   input  logic [31:0] addr_i,
   input  logic        we_i,
   input  logic [3:0]  be_i,
   input  logic [31:0] wdata_i,
   output logic        rvalid_o,
   output logic [31:0] rdata_o,
   output logic        err_o
);

   localparam int unsigned WW = (GntDelay > 0) ? $clog2(GntDelay + 1) : 1;
   localparam int unsigned OW = $clog2(MaxOutstanding + 1);
   localparam int unsigned IW = (Depth > 1) ? $clog2(Depth) : 1;
   localparam logic [WW-1:0] WaitMax = WW'(GntDelay);
   localparam logic [OW-1:0] OutsMax = OW'(MaxOutstanding);
   localparam logic [32:0] SpanBytes = 33'(Depth) * 33'd4;

   generate
      if (RspLatency < 1) begin : g_bad_latency
         $error("RspLatency must be at least 1");
      end
      if (MaxOutstanding < 1) begin : g_bad_outs
         $error("MaxOutstanding must be at least 1");
      end
   endgenerate

   typedef struct packed {
      logic        v;
      logic [31:0] d;
      logic        e;
   } stage_t;

   logic [31:0] mem [Depth];

   logic [WW-1:0] wait_q, wait_d;
   logic [OW-1:0] outs_q, outs_d;
   stage_t        pipe_q [RspLatency];
   stage_t        stage_in;

   logic [32:0]   off;
   logic          in_range;
   logic [IW-1:0] idx;
   logic [31:0]   rd_word;
   logic          retire;

   // Offset in 33 bits so addresses below the base show up as a borrow.
   assign off      = {1'b0, addr_i} - {1'b0, AddrBase};
   assign in_range = !off[32] && (off < SpanBytes);
   assign idx      = IW'(off >> 2);
   assign rd_word  = mem[idx];

   assign retire   = pipe_q[RspLatency-1].v;
   assign rvalid_o = pipe_q[RspLatency-1].v;
   assign rdata_o  = pipe_q[RspLatency-1].d;
   assign err_o    = pipe_q[RspLatency-1].e;

   always_comb begin
      gnt_o    = 1'b0;
      wait_d   = wait_q;
      outs_d   = outs_q;
      stage_in = '0;

      gnt_o = req_i && (wait_q == WaitMax) &&
              ((outs_q < OutsMax) || retire);

      if (!req_i || gnt_o) begin
         wait_d = '0;
      end else if (wait_q != WaitMax) begin
         wait_d = wait_q + 1'b1;
      end

      unique case ({gnt_o, retire})
         2'b10:   outs_d = outs_q + 1'b1;
         2'b01:   outs_d = outs_q - 1'b1;
         default: outs_d = outs_q;
      endcase

      if (gnt_o) begin
         stage_in.v = 1'b1;
         stage_in.e = !in_range;
         stage_in.d = (in_range && !we_i) ? rd_word : 32'h0;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wait_q <= '0;
         outs_q <= '0;
         for (int i = 0; i < RspLatency; i++) begin
            pipe_q[i] <= '0;
         end
      end else begin
         wait_q    <= wait_d;
         outs_q    <= outs_d;
         pipe_q[0] <= stage_in;
         for (int i = 1; i < RspLatency; i++) begin
            pipe_q[i] <= pipe_q[i-1];
         end
      end
   end

   // Memory contents deliberately survive reset.
   always_ff @(posedge clk_i) begin
      if (gnt_o && we_i && in_range) begin
         for (int b = 0; b < 4; b++) begin
            if (be_i[b]) begin
               mem[idx][8*b +: 8] <= wdata_i[8*b +: 8];
            end
         end
      end
   end

   a_outs_bound: assert property (
      @(posedge clk_i) disable iff (rst_i) outs_q <= OutsMax
   );

endmodule

// File: tb/tb_bus_mem_responder.sv
// Directed bench for bus_mem_responder across three parameter sets.
// u0: no delay, latency 1; u1: delay 3, latency 2; u2: latency 4, two outstanding.
module tb_bus_mem_responder;

   logic        clk = 1'b0;
   logic        rst;
   logic [2:0]  req, gnt, we, rvalid, err;
   logic [31:0] addr  [3];
   logic [3:0]  be    [3];
   logic [31:0] wdata [3];
   logic [31:0] rdata [3];

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   bus_mem_responder #(.GntDelay(0), .RspLatency(1), .MaxOutstanding(2)) u0 (
      .clk_i(clk), .rst_i(rst), .req_i(req[0]), .gnt_o(gnt[0]),
      .addr_i(addr[0]), .we_i(we[0]), .be_i(be[0]), .wdata_i(wdata[0]),
      .rvalid_o(rvalid[0]), .rdata_o(rdata[0]), .err_o(err[0])
   );

   bus_mem_responder #(.GntDelay(3), .RspLatency(2), .MaxOutstanding(2)) u1 (
      .clk_i(clk), .rst_i(rst), .req_i(req[1]), .gnt_o(gnt[1]),
      .addr_i(addr[1]), .we_i(we[1]), .be_i(be[1]), .wdata_i(wdata[1]),
      .rvalid_o(rvalid[1]), .rdata_o(rdata[1]), .err_o(err[1])
   );

   bus_mem_responder #(.GntDelay(0), .RspLatency(4), .MaxOutstanding(2)) u2 (
      .clk_i(clk), .rst_i(rst), .req_i(req[2]), .gnt_o(gnt[2]),
      .addr_i(addr[2]), .we_i(we[2]), .be_i(be[2]), .wdata_i(wdata[2]),
      .rvalid_o(rvalid[2]), .rdata_o(rdata[2]), .err_o(err[2])
   );

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [3:0]  be;
      logic [31:0] wdata;
      logic [31:0] rdata;
      logic        err;
   } vec_t;

   vec_t vt [13];

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic xfer(input int k, input logic w, input logic [31:0] a,
                       input logic [3:0] b, input logic [31:0] d,
                       output logic [31:0] rd, output logic e);
      int n;
      rd = '0;
      e  = 1'b0;
      @(negedge clk);
      req[k] = 1'b1; we[k] = w; addr[k] = a; be[k] = b; wdata[k] = d;
      #1;
      n = 0;
      while (!gnt[k] && n < 20) begin
         @(negedge clk); #1; n++;
      end
      chk("xfer_gnt", gnt[k], 1);
      @(negedge clk);
      req[k] = 1'b0;
      #1;
      n = 0;
      while (!rvalid[k] && n < 20) begin
         @(negedge clk); #1; n++;
      end
      chk("xfer_rvalid", rvalid[k], 1);
      rd = rdata[k];
      e  = err[k];
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [31:0] rd;
      logic        e;
      logic [15:0] eg, erv;
      logic [6:0]  rq;
      int          ng, nr;

      vt[0]  = '{1'b1, 32'h10,    4'hF, 32'hDEADBEEF, 32'h0,        1'b0};
      vt[1]  = '{1'b0, 32'h10,    4'hF, 32'h0,        32'hDEADBEEF, 1'b0};
      vt[2]  = '{1'b1, 32'h20,    4'hF, 32'h11223344, 32'h0,        1'b0};
      vt[3]  = '{1'b1, 32'h20,    4'h5, 32'hAABBCCDD, 32'h0,        1'b0};
      vt[4]  = '{1'b0, 32'h20,    4'h0, 32'h0,        32'h11BB33DD, 1'b0};
      vt[5]  = '{1'b0, 32'h10000, 4'hF, 32'h0,        32'h0,        1'b1};
      vt[6]  = '{1'b1, 32'h0,     4'hF, 32'h01020304, 32'h0,        1'b0};
      vt[7]  = '{1'b1, 32'h1000,  4'hF, 32'h55555555, 32'h0,        1'b1};
      vt[8]  = '{1'b1, 32'h1010,  4'hF, 32'h66666666, 32'h0,        1'b1};
      vt[9]  = '{1'b0, 32'h0,     4'hF, 32'h0,        32'h01020304, 1'b0};
      vt[10] = '{1'b0, 32'h13,    4'hF, 32'h0,        32'hDEADBEEF, 1'b0};
      vt[11] = '{1'b1, 32'hFFC,   4'hF, 32'hCAFEF00D, 32'h0,        1'b0};
      vt[12] = '{1'b0, 32'hFFC,   4'hF, 32'h0,        32'hCAFEF00D, 1'b0};

      rst = 1'b1;
      req = '0; we = '0;
      for (int k = 0; k < 3; k++) begin
         addr[k] = '0; be[k] = '0; wdata[k] = '0;
      end
      @(negedge clk);
      @(negedge clk);
      #1;
      for (int k = 0; k < 3; k++) begin
         chk("rst_gnt", gnt[k], 0);
         chk("rst_rvalid", rvalid[k], 0);
         chk("rst_rdata", rdata[k], 0);
         chk("rst_err", err[k], 0);
      end
      @(negedge clk);
      rst = 1'b0;

      // Single transfers, no wait states, latency 1
      for (int i = 0; i < 13; i++) begin
         @(negedge clk);
         req[0] = 1'b1; we[0] = vt[i].we; addr[0] = vt[i].addr;
         be[0] = vt[i].be; wdata[0] = vt[i].wdata;
         #1;
         chk("vec_gnt", gnt[0], 1);
         @(negedge clk);
         req[0] = 1'b0;
         #1;
         chk("vec_rvalid", rvalid[0], 1);
         chk("vec_rdata", rdata[0], vt[i].rdata);
         chk("vec_err", err[0], vt[i].err);
      end

      // Grant delay 3: grant on 4th request cycle, response 2 cycles later
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         req[1] = 1'b1; we[1] = 1'b1; addr[1] = 32'h40;
         be[1] = 4'hF; wdata[1] = 32'h12345678;
         #1;
         chk("gd_gnt", gnt[1], (c == 3) ? 1 : 0);
      end
      @(negedge clk);
      req[1] = 1'b0;
      #1;
      chk("gd_rvalid_early", rvalid[1], 0);
      @(negedge clk);
      #1;
      chk("gd_rvalid", rvalid[1], 1);
      chk("gd_wr_rdata", rdata[1], 0);
      chk("gd_wr_err", err[1], 0);
      @(negedge clk);
      #1;
      chk("gd_rvalid_once", rvalid[1], 0);

      // Drop request after two cycles: wait count must restart
      rq = 7'b1111011;
      for (int c = 0; c < 7; c++) begin
         @(negedge clk);
         req[1] = rq[c]; we[1] = 1'b0; addr[1] = 32'h40;
         #1;
         chk("gd_restart_gnt", gnt[1], (c == 6) ? 1 : 0);
      end
      @(negedge clk);
      req[1] = 1'b0;
      #1;
      chk("gd_rd_early", rvalid[1], 0);
      @(negedge clk);
      #1;
      chk("gd_rd_rvalid", rvalid[1], 1);
      chk("gd_rd_rdata", rdata[1], 32'h12345678);

      // Outstanding limit 2 with latency 4
      for (int i = 0; i < 6; i++) begin
         xfer(2, 1'b1, 32'h100 + 32'(4 * i), 4'hF, 32'hA0000000 + 32'(i), rd, e);
         chk("pre_err", e, 0);
      end
      eg  = 16'h0333;
      erv = 16'h3330;
      ng  = 0;
      nr  = 0;
      for (int c = 0; c < 15; c++) begin
         @(negedge clk);
         req[2] = (ng < 6); we[2] = 1'b0; addr[2] = 32'h100 + 32'(4 * ng);
         #1;
         if (req[2]) chk("burst_gnt", gnt[2], eg[c]);
         chk("burst_rvalid", rvalid[2], erv[c]);
         if (rvalid[2] && nr < 6) begin
            chk("burst_rdata", rdata[2], 32'hA0000000 + 32'(nr));
            nr++;
         end
         chk("burst_outs_bound", (u2.outs_q <= 2), 1);
         if (gnt[2]) ng++;
      end
      req[2] = 1'b0;
      chk("burst_ngrants", ng, 6);
      chk("burst_nresp", nr, 6);

      // Reset with two responses in flight
      @(negedge clk);
      req[2] = 1'b1; addr[2] = 32'h100;
      #1;
      chk("rm_gnt0", gnt[2], 1);
      @(negedge clk);
      addr[2] = 32'h104;
      #1;
      chk("rm_gnt1", gnt[2], 1);
      @(negedge clk);
      req[2] = 1'b0;
      #1;
      rst = 1'b1;
      #1;
      chk("rm_gnt", gnt[2], 0);
      chk("rm_rvalid", rvalid[2], 0);
      chk("rm_rdata", rdata[2], 0);
      chk("rm_err", err[2], 0);
      @(negedge clk);
      rst = 1'b0;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         #1;
         chk("rm_no_rvalid", rvalid[2], 0);
      end
      xfer(2, 1'b0, 32'h104, 4'hF, 32'h0, rd, e);
      chk("rm_keep_rdata", rd, 32'hA0000001);
      chk("rm_keep_err", e, 0);
      xfer(0, 1'b0, 32'h10, 4'hF, 32'h0, rd, e);
      chk("rm_keep_u0", rd, 32'hDEADBEEF);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/bus_mem_responder.md
Name: bus_mem_responder

Overview:
- Simulation memory responder for the host side of the req/gnt/rvalid bus protocol used by the Ibex instruction and data ports and the bus hosts.
- Stands in where a host would connect to the bus, so a host can be exercised without the interconnect.
- Grant delay and response latency are configurable, which exercises wait-state and pipelined-outstanding behaviour.
- Out-of-range accesses return an error response.

Parameters:
- Depth, 1024: memory size in 32-bit words.
- AddrBase, 32'h0: byte address of word 0.
- GntDelay, 0: cycles req_i must be high before gnt_o asserts (0 means same cycle).
- RspLatency, 1: cycles from the grant edge to rvalid_o. Must be 1 or more; enforced by an elaboration assertion.
- MaxOutstanding, 2: maximum number of granted requests not yet responded. Must be 1 or more.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- req_i  in  1  host request.
- gnt_o  out  1  request accepted this cycle.
- addr_i  in  32  byte address; bits [1:0] ignored.
- we_i  in  1  1 = write, 0 = read.
- be_i  in  4  byte enables for writes.
- wdata_i  in  32  write data.
- rvalid_o  out  1  response valid, one cycle per granted request.
- rdata_o  out  32  read data, valid with rvalid_o.
- err_o  out  1  error flag, valid with rvalid_o.

Behaviour:
- Reset values: gnt_o=0, rvalid_o=0, rdata_o=0, err_o=0. Grant counter, outstanding count and response pipeline all clear.
- Reset mid-operation: all pending responses are discarded. Memory contents are not reset.
- Host rule: the host holds req_i, addr_i, we_i, be_i and wdata_i stable from req_i rising until the gnt_o cycle. Behaviour is undefined if it does not.
- Grant counter wait_q:
  - Increments each cycle that req_i=1 and wait_q<GntDelay.
  - Saturates at GntDelay.
  - Clears to 0 on a grant or when req_i=0.
- Grant condition, combinational: gnt_o = req_i & (wait_q==GntDelay) & (outs_q<MaxOutstanding or a response retires this cycle).
  - With GntDelay=0, gnt_o can assert in the same cycle req_i rises.
  - Back-to-back grants are allowed on consecutive cycles, as long as outstanding capacity allows. wait_q restarts from 0 after each grant.
- Address check: in_range = (addr_i >= AddrBase) & (addr_i < AddrBase+Depth*4). Word index = (addr_i-AddrBase)>>2.
- Access at the grant edge:
  - Write, in range: only bytes with be_i set are updated.
  - Read, in range: the whole word is captured regardless of be_i.
  - Out of range: nothing is written, captured data = 0, error bit = 1.
  - Read-after-write: a read granted on a later cycle sees the written data.
- Response pipeline:
  - Shift pipeline of RspLatency stages. Each stage holds {valid, data, err}.
  - A grant loads stage 0.
  - The last stage drives rvalid_o, rdata_o and err_o as registered outputs.
  - A request granted at edge N produces rvalid_o=1 during the cycle after edge N+RspLatency-1, i.e. exactly RspLatency cycles after the gnt_o cycle.
  - Responses return in grant order, at most one per cycle.
  - When rvalid_o=0: rdata_o=0 and err_o=0.
  - Write responses: rdata_o=0, err_o set only when out of range.
- Outstanding count outs_q:
  - +1 on a grant, -1 on a retire (the cycle rvalid_o=1).
  - Simultaneous grant and retire leaves it unchanged.
  - It never exceeds MaxOutstanding; an SVA checks this.
  - When MaxOutstanding < RspLatency, grants stall and throughput drops to MaxOutstanding per RspLatency cycles.
- No internal state machine beyond the counters; the responder is always ready to accept, subject to the grant condition.

Test Plan:
- GntDelay=0, RspLatency=1:
  - Write 0xDEADBEEF, be=4'hF, to addr 0x10 -> gnt_o in the req cycle, rvalid_o next cycle with err_o=0.
  - Then read 0x10 -> rdata_o=0xDEADBEEF.
- Byte enables: mem[0x20]=0x11223344, then write 0xAABBCCDD with be=4'b0101 -> a read returns 0x11BB33DD.
- GntDelay=3, RspLatency=2: req held -> gnt_o on the 4th req cycle, rvalid_o exactly 2 cycles after the gnt_o cycle. Dropping req_i after 2 cycles and reasserting -> count restarts, no grant until 4 cycles after reassertion.
- MaxOutstanding=2, RspLatency=4, req held for 6 back-to-back reads of distinct addresses:
  - Grants on cycles 0 and 1, then a stall until the first retire.
  - Responses arrive in order with the correct data.
  - outs_q never exceeds 2.
- Error path: read 0x00010000 with Depth=1024 -> rvalid_o with err_o=1 and rdata_o=0. An out-of-range write leaves memory unchanged, checked by reading back a known word.
- Reset mid-operation: assert rst_i while 2 responses are pending -> no rvalid_o after reset, all outputs 0. Memory written before reset still reads back correctly.
